// File: rtl/alu_issue.sv
// alu_issue -- decode/issue stage at the ID/EX boundary of the 16-bit pipeline.
//
// Accepts one instruction per cycle over id_valid/id_ready. Each instruction is
// decoded into a 4-bit ALU function code and operands are resolved from the
// register file or the MEM/WB bypass paths. The decoded bundle is registered
// into the EX operand register. The stage supports RAW-hazard stalls,
// back-pressure from EX and a flush.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid, id_instr, id_ready  instruction handshake (id_ready is combinational)
//   rf_rs_addr/rf_rt_addr         register-file read addresses (combinational)
//   rf_rs_data/rf_rt_data         register-file read data, same cycle
//   mem_wb_en/addr/data           EX/MEM result bypass
//   wb_en/addr/data               MEM/WB result bypass
//   flush                         kill the ID instruction and the EX register
//   ex_ready                      EX consumes the register this cycle
//   ex_*                          registered EX-stage bundle
//   ex_illegal                    last accepted word was undefined
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  output logic        id_ready,
  output logic [2:0]  rf_rs_addr,
  output logic [2:0]  rf_rt_addr,
  input  logic [15:0] rf_rs_data,
  input  logic [15:0] rf_rt_data,
  input  logic        mem_wb_en,
  input  logic [2:0]  mem_wb_addr,
  input  logic [15:0] mem_wb_data,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [15:0] ex_in1,
  output logic [15:0] ex_in2,
  output logic [3:0]  ex_op,
  output logic [2:0]  ex_rd,
  output logic        ex_wb_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch,
  output logic [15:0] ex_store_data,
  output logic        ex_illegal
);

  // ALU function codes shared with the ALU.
  localparam logic [3:0] FUNCT_ADD  = 4'h0;
  localparam logic [3:0] FUNCT_SUB  = 4'h1;
  localparam logic [3:0] FUNCT_AND  = 4'h2;
  localparam logic [3:0] FUNCT_OR   = 4'h3;
  localparam logic [3:0] FUNCT_SLT  = 4'h4;
  localparam logic [3:0] FUNCT_SLTU = 4'h5;

  localparam logic [2:0] OPC_R    = 3'b000;
  localparam logic [2:0] OPC_ADDI = 3'b001;
  localparam logic [2:0] OPC_SLTI = 3'b010;
  localparam logic [2:0] OPC_LW   = 3'b011;
  localparam logic [2:0] OPC_SW   = 3'b100;
  localparam logic [2:0] OPC_BEQ  = 3'b101;

  logic [2:0]  opcode, rsAddr, rtAddr, rdAddr;
  logic [3:0]  funct;
  logic [15:0] imm16;

  assign opcode = id_instr[15:13];
  assign rsAddr = id_instr[12:10];
  assign rtAddr = id_instr[9:7];
  assign rdAddr = id_instr[6:4];
  assign funct  = id_instr[3:0];
  assign imm16  = {{9{id_instr[6]}}, id_instr[6:0]};

  assign rf_rs_addr = rsAddr;
  assign rf_rt_addr = rtAddr;

  // Register zero always reads as 0; the younger EX/MEM result beats MEM/WB.
  function automatic logic [15:0] resolveOperand(
    input logic [2:0]  addr,
    input logic [15:0] rfData,
    input logic        mwEn,
    input logic [2:0]  mwAddr,
    input logic [15:0] mwData,
    input logic        wEn,
    input logic [2:0]  wAddr,
    input logic [15:0] wData
  );
    if (addr == 3'd0)                  return 16'h0000;
    else if (mwEn && (mwAddr == addr)) return mwData;
    else if (wEn && (wAddr == addr))   return wData;
    else                               return rfData;
  endfunction

  logic [15:0] rsVal, rtVal;

  assign rsVal = resolveOperand(rsAddr, rf_rs_data, mem_wb_en, mem_wb_addr, mem_wb_data,
                                wb_en, wb_addr, wb_data);
  assign rtVal = resolveOperand(rtAddr, rf_rt_data, mem_wb_en, mem_wb_addr, mem_wb_data,
                                wb_en, wb_addr, wb_data);

  logic       decLegal, decUseImm, decUsesRt, decWb, decMemRd, decMemWr, decBranch;
  logic [3:0] decOp;
  logic [2:0] decDest;

  always_comb begin
    decLegal  = 1'b0;
    decUseImm = 1'b0;
    decUsesRt = 1'b0;
    decWb     = 1'b0;
    decMemRd  = 1'b0;
    decMemWr  = 1'b0;
    decBranch = 1'b0;
    decOp     = FUNCT_ADD;
    decDest   = rtAddr;
    case (opcode)
      OPC_R: begin
        decLegal  = (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
                    (funct == FUNCT_OR)  || (funct == FUNCT_SLT) || (funct == FUNCT_SLTU);
        decOp     = funct;
        decUsesRt = 1'b1;
        decDest   = rdAddr;
        decWb     = 1'b1;
      end
      OPC_ADDI: begin
        decLegal  = 1'b1;
        decUseImm = 1'b1;
        decWb     = 1'b1;
      end
      OPC_SLTI: begin
        decLegal  = 1'b1;
        decOp     = FUNCT_SLT;
        decUseImm = 1'b1;
        decWb     = 1'b1;
      end
      OPC_LW: begin
        decLegal  = 1'b1;
        decUseImm = 1'b1;
        decWb     = 1'b1;
        decMemRd  = 1'b1;
      end
      OPC_SW: begin
        decLegal  = 1'b1;
        decUseImm = 1'b1;
        decUsesRt = 1'b1;
        decMemWr  = 1'b1;
      end
      OPC_BEQ: begin
        decLegal  = 1'b1;
        decOp     = FUNCT_SUB;
        decUsesRt = 1'b1;
        decBranch = 1'b1;
      end
      default: decLegal = 1'b0;
    endcase
  end

  logic        ex_valid_q, ex_valid_d;
  logic [15:0] ex_in1_q, ex_in1_d, ex_in2_q, ex_in2_d, ex_store_q, ex_store_d;
  logic [3:0]  ex_op_q, ex_op_d;
  logic [2:0]  ex_rd_q, ex_rd_d;
  logic        ex_wb_q, ex_wb_d, ex_mem_rd_q, ex_mem_rd_d, ex_mem_wr_q, ex_mem_wr_d;
  logic        ex_branch_q, ex_branch_d, ex_illegal_q, ex_illegal_d;

  // The EX-stage result is not yet on any bypass path, so a dependent
  // instruction must wait one cycle until it reaches EX/MEM.
  logic hazard, exHeld, accept;

  assign hazard = decLegal && ex_valid_q && ex_wb_q &&
                  (((rsAddr != 3'd0) && (rsAddr == ex_rd_q)) ||
                   (decUsesRt && (rtAddr != 3'd0) && (rtAddr == ex_rd_q)));
  assign exHeld   = ex_valid_q && !ex_ready;
  assign id_ready = flush || (!hazard && !exHeld);
  assign accept   = id_valid && id_ready && !flush;

  // Flush wins, a held entry is frozen, otherwise the register takes either
  // the accepted instruction or a bubble. ex_illegal tracks the last accepted
  // word and is therefore untouched by plain bubbles.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_in1_d     = ex_in1_q;
    ex_in2_d     = ex_in2_q;
    ex_store_d   = ex_store_q;
    ex_op_d      = ex_op_q;
    ex_rd_d      = ex_rd_q;
    ex_wb_d      = ex_wb_q;
    ex_mem_rd_d  = ex_mem_rd_q;
    ex_mem_wr_d  = ex_mem_wr_q;
    ex_branch_d  = ex_branch_q;
    ex_illegal_d = ex_illegal_q;
    if (flush || !exHeld) begin
      ex_valid_d  = 1'b0;
      ex_in1_d    = 16'h0000;
      ex_in2_d    = 16'h0000;
      ex_store_d  = 16'h0000;
      ex_op_d     = 4'h0;
      ex_rd_d     = 3'd0;
      ex_wb_d     = 1'b0;
      ex_mem_rd_d = 1'b0;
      ex_mem_wr_d = 1'b0;
      ex_branch_d = 1'b0;
      if (flush) begin
        ex_illegal_d = 1'b0;
      end else if (accept) begin
        ex_illegal_d = !decLegal;
        if (decLegal) begin
          ex_valid_d  = 1'b1;
          ex_in1_d    = rsVal;
          ex_in2_d    = decUseImm ? imm16 : rtVal;
          ex_store_d  = decMemWr ? rtVal : 16'h0000;
          ex_op_d     = decOp;
          ex_rd_d     = decDest;
          ex_wb_d     = decWb && (decDest != 3'd0);
          ex_mem_rd_d = decMemRd;
          ex_mem_wr_d = decMemWr;
          ex_branch_d = decBranch;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_in1_q     <= 16'h0000;
      ex_in2_q     <= 16'h0000;
      ex_store_q   <= 16'h0000;
      ex_op_q      <= 4'h0;
      ex_rd_q      <= 3'd0;
      ex_wb_q      <= 1'b0;
      ex_mem_rd_q  <= 1'b0;
      ex_mem_wr_q  <= 1'b0;
      ex_branch_q  <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_in1_q     <= ex_in1_d;
      ex_in2_q     <= ex_in2_d;
      ex_store_q   <= ex_store_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_wb_q      <= ex_wb_d;
      ex_mem_rd_q  <= ex_mem_rd_d;
      ex_mem_wr_q  <= ex_mem_wr_d;
      ex_branch_q  <= ex_branch_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_in1        = ex_in1_q;
  assign ex_in2        = ex_in2_q;
  assign ex_op         = ex_op_q;
  assign ex_rd         = ex_rd_q;
  assign ex_wb_en      = ex_wb_q;
  assign ex_mem_rd     = ex_mem_rd_q;
  assign ex_mem_wr     = ex_mem_wr_q;
  assign ex_branch     = ex_branch_q;
  assign ex_store_data = ex_store_q;
  assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- directed testbench for alu_issue.
// Drives a linear sequence of instructions against a small register-file
// model and compares the EX bundle to hand-computed values.
module tb_alu_issue;

  localparam logic [3:0] FUNCT_ADD = 4'h0;
  localparam logic [3:0] FUNCT_SUB = 4'h1;

  logic        clk, rst_n, id_valid, id_ready, flush, ex_ready;
  logic [15:0] id_instr;
  logic [2:0]  rf_rs_addr, rf_rt_addr;
  logic [15:0] rf_rs_data, rf_rt_data;
  logic        mem_wb_en, wb_en;
  logic [2:0]  mem_wb_addr, wb_addr;
  logic [15:0] mem_wb_data, wb_data;
  logic        ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal;
  logic [15:0] ex_in1, ex_in2, ex_store_data;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;

  logic [15:0] regs [8];
  int vectors = 0;
  int miscompares = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: same-cycle read.
  always_comb begin
    rf_rs_data = regs[rf_rs_addr];
    rf_rt_data = regs[rf_rt_addr];
  end

  function automatic logic [15:0] rtype(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [3:0] f);
    return {3'b000, rs, rt, rd, f};
  endfunction

  function automatic logic [15:0] itype(input logic [2:0] opc, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 16'h0000; flush = 1'b0; ex_ready = 1'b1;
    mem_wb_en = 1'b0; mem_wb_addr = 3'd0; mem_wb_data = 16'h0000;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;

    // Reset state
    #2;
    checkOutput("rst_ex_valid", ex_valid, 1'b0);
    checkOutput("rst_ex_illegal", ex_illegal, 1'b0);
    checkOutput("rst_ex_in1", ex_in1, 16'h0000);
    checkOutput("rst_id_ready", id_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r3,r1,r2
    id_valid = 1'b1;
    id_instr = rtype(3'd1, 3'd2, 3'd3, FUNCT_ADD);
    #1;
    checkOutput("add_rs_addr", rf_rs_addr, 3'd1);
    checkOutput("add_rt_addr", rf_rt_addr, 3'd2);
    checkOutput("add_id_ready", id_ready, 1'b1);
    applyStimulus;
    checkOutput("add_valid", ex_valid, 1'b1);
    checkOutput("add_in1", ex_in1, 16'd5);
    checkOutput("add_in2", ex_in2, 16'd7);
    checkOutput("add_op", ex_op, FUNCT_ADD);
    checkOutput("add_rd", ex_rd, 3'd3);
    checkOutput("add_wb", ex_wb_en, 1'b1);

    // ADDI r4,r1,0x7F -> immediate sign-extends to 0xFFFF
    id_instr = itype(3'b001, 3'd1, 3'd4, 7'h7F);
    applyStimulus;
    checkOutput("addi_in1", ex_in1, 16'd5);
    checkOutput("addi_in2", ex_in2, 16'hFFFF);
    checkOutput("addi_rd", ex_rd, 3'd4);
    checkOutput("addi_wb", ex_wb_en, 1'b1);

    // Forwarding priority: EX/MEM beats MEM/WB beats register file
    regs[1] = 16'h0000;
    mem_wb_en = 1'b1; mem_wb_addr = 3'd1; mem_wb_data = 16'h1111;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h2222;
    id_instr = rtype(3'd1, 3'd2, 3'd5, FUNCT_ADD);
    applyStimulus;
    checkOutput("fwd_memwb_in1", ex_in1, 16'h1111);
    checkOutput("fwd_memwb_in2", ex_in2, 16'd7);
    mem_wb_en = 1'b0;
    applyStimulus;
    checkOutput("fwd_wb_in1", ex_in1, 16'h2222);
    wb_en = 1'b0;
    regs[1] = 16'd5;

    // RAW stall: LW r2,3(r1) then ADD r3,r2,r1
    id_instr = itype(3'b011, 3'd1, 3'd2, 7'd3);
    applyStimulus;
    checkOutput("lw_in2", ex_in2, 16'd3);
    checkOutput("lw_mem_rd", ex_mem_rd, 1'b1);
    checkOutput("lw_rd", ex_rd, 3'd2);
    id_instr = rtype(3'd2, 3'd1, 3'd3, FUNCT_ADD);
    #1;
    checkOutput("raw_id_ready_stall", id_ready, 1'b0);
    applyStimulus;
    checkOutput("raw_bubble_valid", ex_valid, 1'b0);
    checkOutput("raw_bubble_mem_rd", ex_mem_rd, 1'b0);
    checkOutput("raw_id_ready_after", id_ready, 1'b1);
    mem_wb_en = 1'b1; mem_wb_addr = 3'd2; mem_wb_data = 16'h00AB;
    applyStimulus;
    checkOutput("raw_add_valid", ex_valid, 1'b1);
    checkOutput("raw_add_in1", ex_in1, 16'h00AB);
    checkOutput("raw_add_in2", ex_in2, 16'd5);
    mem_wb_en = 1'b0;

    // SW r2,-1(r1)
    id_instr = itype(3'b100, 3'd1, 3'd2, 7'h7F);
    applyStimulus;
    checkOutput("sw_mem_wr", ex_mem_wr, 1'b1);
    checkOutput("sw_wb", ex_wb_en, 1'b0);
    checkOutput("sw_in2", ex_in2, 16'hFFFF);
    checkOutput("sw_store", ex_store_data, 16'd7);

    // Back-pressure: bundle frozen for three cycles
    id_instr = itype(3'b101, 3'd1, 3'd2, 7'd0);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("hold_id_ready", id_ready, 1'b0);
      applyStimulus;
      checkOutput("hold_valid", ex_valid, 1'b1);
      checkOutput("hold_mem_wr", ex_mem_wr, 1'b1);
      checkOutput("hold_store", ex_store_data, 16'd7);
      checkOutput("hold_branch", ex_branch, 1'b0);
    end
    ex_ready = 1'b1;
    applyStimulus;
    checkOutput("beq_branch", ex_branch, 1'b1);
    checkOutput("beq_op", ex_op, FUNCT_SUB);
    checkOutput("beq_in2", ex_in2, 16'd7);
    checkOutput("beq_wb", ex_wb_en, 1'b0);

    // Flush beats hold and drops the handshaken ID instruction
    ex_ready = 1'b0;
    flush = 1'b1;
    id_instr = rtype(3'd1, 3'd2, 3'd6, FUNCT_ADD);
    #1;
    checkOutput("flush_id_ready", id_ready, 1'b1);
    applyStimulus;
    checkOutput("flush_valid", ex_valid, 1'b0);
    checkOutput("flush_branch", ex_branch, 1'b0);
    checkOutput("flush_illegal", ex_illegal, 1'b0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Illegal opcode and illegal funct
    id_instr = 16'hC000;
    applyStimulus;
    checkOutput("illop_valid", ex_valid, 1'b0);
    checkOutput("illop_illegal", ex_illegal, 1'b1);
    id_instr = rtype(3'd1, 3'd2, 3'd3, 4'hF);
    applyStimulus;
    checkOutput("illfn_valid", ex_valid, 1'b0);
    checkOutput("illfn_illegal", ex_illegal, 1'b1);

    // ADD r0,r1,r2: valid but no writeback
    id_instr = rtype(3'd1, 3'd2, 3'd0, FUNCT_ADD);
    applyStimulus;
    checkOutput("r0dst_valid", ex_valid, 1'b1);
    checkOutput("r0dst_wb", ex_wb_en, 1'b0);
    checkOutput("r0dst_illegal", ex_illegal, 1'b0);

    // rs=r0 ignores register file and bypass
    regs[0] = 16'h5555;
    mem_wb_en = 1'b1; mem_wb_addr = 3'd0; mem_wb_data = 16'hBEEF;
    id_instr = rtype(3'd0, 3'd2, 3'd3, FUNCT_ADD);
    applyStimulus;
    checkOutput("r0src_in1", ex_in1, 16'h0000);
    checkOutput("r0src_in2", ex_in2, 16'd7);
    mem_wb_en = 1'b0;

    // Reset asserted mid-stall, then normal acceptance
    id_instr = itype(3'b011, 3'd1, 3'd2, 7'd3);
    applyStimulus;
    id_instr = rtype(3'd2, 3'd1, 3'd3, FUNCT_ADD);
    #1;
    checkOutput("rststall_id_ready", id_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rststall_valid", ex_valid, 1'b0);
    checkOutput("rststall_id_ready_rst", id_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    applyStimulus;
    checkOutput("rststall_add_valid", ex_valid, 1'b1);
    checkOutput("rststall_add_in1", ex_in1, 16'd7);
    checkOutput("rststall_add_rd", ex_rd, 3'd3);

    // Idle input drains to a bubble
    id_valid = 1'b0;
    applyStimulus;
    checkOutput("idle_valid", ex_valid, 1'b0);
    checkOutput("idle_wb", ex_wb_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage (ID/EX boundary) of the 16-bit pipeline; the producing end of the ALU's `in1`/`in2`/`op` interface. It accepts one instruction per cycle over a valid/ready handshake and decodes it into a 4-bit ALU function code from `general_architecture/funct.vh`. Operands are selected from the register file or forwarded from the MEM/WB stages. The result is registered into the EX-stage operand register, with RAW-hazard stalling, back-pressure and flush.

## Interface
- Parameters: none (data width fixed at 16, 8 registers, `r0` reads as zero).
- `clk  in  1`: clock, all state on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `id_valid  in  1`: `id_instr` is valid.
- `id_instr  in  16`: instruction word.
- `id_ready  out  1`: instruction accepted this cycle when `id_valid & id_ready`; combinational.
- `rf_rs_addr`, `rf_rt_addr`  out  3: combinational register-file read addresses, equal to `id_instr[12:10]` and `id_instr[9:7]`.
- `rf_rs_data`, `rf_rt_data`  in  16: register-file read data, same cycle.
- `mem_wb_en  in  1`, `mem_wb_addr  in  3`, `mem_wb_data  in  16`: EX/MEM-stage result bypass.
- `wb_en  in  1`, `wb_addr  in  3`, `wb_data  in  16`: MEM/WB-stage result bypass.
- `flush  in  1`: kill the instruction in ID and the EX register.
- `ex_ready  in  1`: EX stage consumes the register this cycle.
- `ex_valid  out  1`, `ex_in1  out  16`, `ex_in2  out  16`, `ex_op  out  4`, `ex_rd  out  3`, `ex_wb_en  out  1`, `ex_mem_rd  out  1`, `ex_mem_wr  out  1`, `ex_branch  out  1`, `ex_store_data  out  16`: registered EX-stage bundle.
- `ex_illegal  out  1`: registered; the last accepted word had an undefined opcode.

## Operation
- Instruction format:
  - `[15:13]` opcode, `[12:10]` rs, `[9:7]` rt.
  - R-type: `[6:4]` rd, `[3:0]` funct.
  - I-type: `[6:0]` imm7, sign-extended to 16 bits.
- Decode per opcode:
  - `000` R: `op=funct`, in2=rt value, dest rd, wb=1.
  - `001` ADDI: `FUNCT_ADD`, in2=imm, dest rt, wb=1.
  - `010` SLTI: `FUNCT_SLT`, in2=imm, dest rt, wb=1.
  - `011` LW: `FUNCT_ADD`, in2=imm, dest rt, wb=1, mem_rd=1.
  - `100` SW: `FUNCT_ADD`, in2=imm, `ex_store_data`=rt value, wb=0, mem_wr=1.
  - `101` BEQ: `FUNCT_SUB`, in2=rt value, branch=1, wb=0.
  - `110`/`111`: illegal. Inserted as a bubble (`ex_valid=0`), `ex_illegal=1`.
- R-type funct not in {ADD, SUB, AND, OR, SLTU, SLT}: treated as illegal.
- Destination `r0` forces `ex_wb_en=0`.
- `ex_in1` = rs value in all types.
- Operand value resolution, highest priority first:
  1. address 0 → 0;
  2. `mem_wb_en` and address match → `mem_wb_data`;
  3. `wb_en` and address match → `wb_data`;
  4. `rf_*_data`.
- Source usage: rs is used by all legal opcodes. rt is used only by R, SW and BEQ.
- Hazard stall: stall when `ex_valid & ex_wb_en` and `ex_rd` equals a used nonzero source. Its result is not yet bypassable.
- Effect of a stall: `id_ready=0`, and a bubble is written into the EX register if `ex_ready`.
- `id_ready = ~hazard & (ex_ready | ~ex_valid)`, or `1` during `flush`.

## Timing
- Reset (async, `rst_n=0`): every `ex_*` output is 0, `ex_illegal=0`. `id_ready` follows its equation with `ex_valid=0`.
- Latency: an instruction accepted at edge N is presented on `ex_*` after edge N, for one cycle minimum.
- Hold: `ex_valid & ~ex_ready` freezes the whole EX bundle, and `id_ready=0`.
- Empty register: bubbles load only when the register is empty or consumed; a held valid entry is never overwritten.
- `flush` has priority over stall and hold:
  - next edge `ex_valid=0`, `ex_illegal=0`;
  - any handshaken ID instruction is dropped.
- Bubble fields: on a bubble or flush, every `ex_*` control bit is 0. Data fields are don't-care but driven 0.
- Reset asserted mid-stall clears state immediately. The first edge after release accepts normally.

## Test plan
- ADD: with `r1=5`, `r2=7`, issue R-type `ADD r3,r1,r2` → next cycle `ex_in1=5`, `ex_in2=7`, `ex_op=FUNCT_ADD`, `ex_rd=3`, `ex_wb_en=1`.
- ADDI: `ADDI r4,r1,imm7=0x7F` → `ex_in2=0xFFFF`.
- Forwarding priority: `mem_wb` (r1=0x1111) and `wb` (r1=0x2222) both target r1, rf r1=0 → `ex_in1=0x1111`.
- RAW stall: `LW r2` followed by `ADD r3,r2,r1` with `ex_ready=1`:
  - `id_ready=0` one cycle, then a bubble (`ex_valid=0`);
  - the ADD issues the next cycle.
- Back-pressure and flush:
  - `ex_ready=0` for 3 cycles → bundle stable, `id_ready=0`;
  - `flush` pulse → `ex_valid=0` next edge.
- Illegal and r0 cases:
  - opcode `110` → `ex_valid=0`, `ex_illegal=1`;
  - `ADD r0,r1,r2` → `ex_valid=1`, `ex_wb_en=0`;
  - rs=r0 with `mem_wb` targeting r0 → `ex_in1=0`.
